// File: rtl/output_display.sv
// 4-digit multiplexed 7-segment driver for the output register.
// Latches writes, converts to sign/magnitude BCD by double-dabble, and scans continuously.
module output_display #(
    parameter int unsigned CLK_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus,
    input  logic       en_write_out,
    input  logic       signed_mode,
    output logic [7:0] value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] digit_en
);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    localparam logic [15:0] LP_TC = 16'(CLK_DIV - 1);

    state_t      r_state, w_state_next;
    logic [2:0]  r_step;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic        r_neg_pend;
    logic [3:0]  r_ones, r_tens, r_hund;
    logic        r_tens_blank, r_hund_blank, r_minus;
    logic [15:0] r_presc;
    logic [1:0]  r_idx;

    logic        w_neg;
    logic [7:0]  w_mag;
    logic        w_last;
    logic [11:0] w_bcd_adj;
    logic [11:0] w_bcd_shift;
    logic [3:0]  w_digit;
    logic        w_blank;

    always_comb begin
        w_neg = signed_mode & bus[7];
        w_mag = w_neg ? (~bus + 8'd1) : bus;
    end

    assign w_last = (r_state == S_CONV) && (r_step == 3'd7);
    assign busy   = (r_state == S_CONV);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
        w_bcd_shift = {w_bcd_adj[10:0], r_bin[7]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // A write always restarts conversion, even on the edge that would have completed one.
    always_comb begin
        w_state_next = r_state;
        if (en_write_out)
            w_state_next = S_CONV;
        else if (w_last)
            w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value        <= '0;
            r_step       <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_neg_pend   <= 1'b0;
            r_ones       <= '0;
            r_tens       <= '0;
            r_hund       <= '0;
            r_tens_blank <= 1'b1;
            r_hund_blank <= 1'b1;
            r_minus      <= 1'b0;
        end else if (en_write_out) begin
            value      <= bus;
            r_bin      <= w_mag;
            r_bcd      <= '0;
            r_step     <= '0;
            r_neg_pend <= w_neg;
        end else if (r_state == S_CONV) begin
            r_bin  <= {r_bin[6:0], 1'b0};
            r_bcd  <= w_bcd_shift;
            r_step <= r_step + 3'd1;
            if (w_last) begin
                r_hund       <= w_bcd_shift[11:8];
                r_tens       <= w_bcd_shift[7:4];
                r_ones       <= w_bcd_shift[3:0];
                r_hund_blank <= (w_bcd_shift[11:8] == 4'd0);
                r_tens_blank <= (w_bcd_shift[11:4] == 8'd0);
                r_minus      <= r_neg_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == LP_TC) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    always_comb begin
        w_digit = r_ones;
        w_blank = 1'b0;
        seg     = '0;
        case (r_idx)
            2'd0: w_digit = r_ones;
            2'd1: begin w_digit = r_tens; w_blank = r_tens_blank; end
            2'd2: begin w_digit = r_hund; w_blank = r_hund_blank; end
            default: w_blank = 1'b1;
        endcase
        if (r_idx == 2'd3) begin
            seg = r_minus ? 7'b1000000 : 7'b0000000;
        end else if (!w_blank) begin
            case (w_digit)
                4'd0:    seg = 7'b0111111;
                4'd1:    seg = 7'b0000110;
                4'd2:    seg = 7'b1011011;
                4'd3:    seg = 7'b1001111;
                4'd4:    seg = 7'b1100110;
                4'd5:    seg = 7'b1101101;
                4'd6:    seg = 7'b1111101;
                4'd7:    seg = 7'b0000111;
                4'd8:    seg = 7'b1111111;
                4'd9:    seg = 7'b1101111;
                default: seg = 7'b0000000;
            endcase
        end
        digit_en = 4'b0001 << r_idx;
    end

endmodule

// File: doc/output_display.md
# output_display

Sequential output-display driver that reads the machine's 8-bit output register and shows it on a 4-digit, time-multiplexed 7-segment display. It latches the value written to the output register, converts it to decimal with a multi-cycle shift-and-add-3 (double-dabble) engine, and scans the digits continuously. It sits on the machine's bus and output-register write strobe, outside the CPU core.

## Interface
Parameters:
- `CLK_DIV`, default 1000: clock cycles each digit stays lit; legal range 1..65535.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `bus`  input  8  machine data bus.
- `en_write_out`  input  1  output-register write strobe; `bus` is captured on the rising edge where this is high.
- `signed_mode`  input  1  when 1, interpret the value as two's complement; sampled together with `bus`.
- `value`  output  8  last captured raw value.
- `busy`  output  1  conversion in progress.
- `seg`  output  7  segment drive `{g,f,e,d,c,b,a}`, active-high.
- `digit_en`  output  4  one-hot digit select, active-high; bit 0 is the rightmost digit.

## Operation
- Reset (asynchronous assert, `reset`=0):
  - `value`=0, `busy`=0, scan index=0, prescaler=0.
  - Display buffer holds ones=0, tens=blank, hundreds=blank, sign=blank.
  - So `digit_en`=4'b0001 and `seg`=7'b0111111 ("0") immediately.
- Capture: when `en_write_out`=1 at an edge:
  - `bus` is stored into `value` and the mode bit is latched.
  - Conversion starts (IDLE->CONV); `busy`=1.
- Magnitude rule:
  - Unsigned mode, or signed mode with bit7=0: magnitude = value.
  - Signed mode with bit7=1: magnitude = (~value+1) as 8-bit unsigned, so 8'h80 gives 128; the negative flag is set.
- CONV state:
  - Runs for 8 cycles. Each cycle: add 3 to every BCD nibble that is >=5, then shift the 12-bit BCD/8-bit binary pair left by 1.
  - After the 8th cycle, the display buffer is loaded atomically and the block returns to IDLE with `busy`=0.
  - The display keeps showing the previous result for the whole conversion.
- Write during CONV: the new value is captured and the conversion restarts from cycle 1 (latest write wins); the earlier conversion is discarded.
- Leading-zero blanking:
  - Hundreds digit is blank if it is 0.
  - Tens digit is blank if hundreds and tens are both 0.
  - Ones digit is always shown.
- Sign digit (digit 3): shows minus (7'b1000000) when the negative flag is set, otherwise blank (7'b0000000).
- Segment codes for 0-9 (g..a): 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
- Scan:
  - The prescaler counts 0..CLK_DIV-1. On its terminal count it wraps to 0 and the index advances 0->1->2->3->0.
  - `digit_en` = 1<<index. `seg` is a combinational decode of the buffer entry selected by the index.
  - Scanning is independent of conversion and never stalls.

## Timing
- Write strobe on edge k: `value` updates on edge k and `busy` is high after edge k.
- The display buffer updates on edge k+8 and `busy` falls after edge k+8. Total latency is 8 cycles.
- A write on edge k+j (1<=j<=8) moves completion to edge k+j+8. A write on edge k+8 itself wins, and its conversion completes at k+16.
- With `CLK_DIV`=N, each digit is lit for exactly N cycles; a full frame is 4N cycles.
- With `CLK_DIV`=1, the index advances every cycle.
- `reset` asserted mid-conversion: everything aborts immediately to the reset values. After deassertion, the first edge is normal operation.
- `seg` and `digit_en` change only on clock edges or on reset, never from `bus` directly.

## Test plan
- Reset, then hold idle for 4 frames with `CLK_DIV`=4 -> `digit_en` cycles 0001,0010,0100,1000 every 4 cycles; `seg` is 0111111 on digit 0 and 0000000 on the others; `busy`=0.
- Write 8'd255 unsigned -> `busy` high for exactly 8 cycles; afterwards digits 3..0 show blank,2,5,5 (`seg` 0000000,1011011,1101101,1101101).
- Write 8'hFF with `signed_mode`=1 -> digits show "-",blank,blank,"1"; write 8'h80 signed -> "-","1","2","8"; write 8'h80 unsigned -> blank,"1","2","8".
- Write 8'd7, then write 8'd42 three cycles later -> the display never shows 7; it shows blank,blank,"4","2" 8 cycles after the second write; `busy` stays high continuously for 11 cycles.
- Write 8'd100, then assert `reset` at cycle 4 of the conversion -> outputs return immediately to the reset values; after release, the display shows "0" and `busy`=0.
- Write 8'd9 while the scan index is at digit 2 -> the scan phase is unaffected (the index advances on schedule); digit 0 shows "9" from completion onward.
